// File: rtl/mem_stage_pkg.sv
// Shared EX/MEM/WB bundle layouts, widths and field offsets.
package mem_stage_pkg;

   localparam int TO_MEM_W = 75;
   localparam int TO_WB_W  = 71;
   localparam int FWD_W    = 37;

   // EX->MEM bundle field offsets (LSB of each field)
   localparam int MEM_PC_LSB     = 43;
   localparam int MEM_ALU_LSB    = 11;
   localparam int MEM_RD1B_BIT   = 10;
   localparam int MEM_RD2B_BIT   = 9;
   localparam int MEM_RD4B_BIT   = 8;
   localparam int MEM_SIGNED_BIT = 7;
   localparam int MEM_DEST_LSB   = 2;
   localparam int MEM_GRWE_BIT   = 1;
   localparam int MEM_SYS_BIT    = 0;

   // MEM->WB bundle field offsets
   localparam int WB_PC_LSB     = 39;
   localparam int WB_RESULT_LSB = 7;
   localparam int WB_DEST_LSB   = 2;
   localparam int WB_GRWE_BIT   = 1;
   localparam int WB_SYS_BIT    = 0;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] alu_result;
      logic        rd1b;
      logic        rd2b;
      logic        rd4b;
      logic        rd_signed;
      logic [4:0]  dest;
      logic        gr_we;
      logic        ex_sys;
   } mem_bundle_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] final_result;
      logic [4:0]  dest;
      logic        gr_we;
      logic        ex_sys;
   } wb_bundle_t;

endpackage

// File: rtl/mem_stage_load_align.sv
// Combinational load-data extraction: selects byte/half/word from the SRAM
// word by address offset and sign- or zero-extends it.
module mem_stage_load_align (
   input  logic [31:0] rdata,
   input  logic [1:0]  off,
   input  logic        rd1b,
   input  logic        rd2b,
   input  logic        rd4b,
   input  logic        rd_signed,
   output logic [31:0] load_result
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Pick the addressed byte/half, then extend to the access width requested.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no path infers a latch.
      load_result = 32'h0;
      byte_sel    = rdata[8*off +: 8];
      half_sel    = off[1] ? rdata[31:16] : rdata[15:0];
      if (rd1b)
         load_result = {{24{rd_signed & byte_sel[7]}}, byte_sel};
      else if (rd2b)
         load_result = {{16{rd_signed & half_sel[15]}}, half_sel};
      else if (rd4b)
         load_result = rdata;
   end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: holds the EX bundle, captures the one-cycle SRAM read
// data (holding it across WB stalls), forms the final result and forwards it.
module mem_stage
   import mem_stage_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic                wb_ex,
   input  logic                EX_to_MEM_valid,
   input  logic [TO_MEM_W-1:0] to_MEM_data,
   output logic                MEM_allow_in,
   input  logic [31:0]         data_sram_rdata,
   input  logic                WB_allow_in,
   output logic                MEM_to_WB_valid,
   output logic [TO_WB_W-1:0]  to_WB_data,
   output logic [FWD_W-1:0]    MEM_forward
);

   mem_bundle_t bundle_q;
   logic        valid_q;
   logic        first_cyc_q;
   logic [31:0] rdata_hold_q;

   logic        accept;
   logic        any_load;
   logic [31:0] rdata_eff;
   logic [31:0] load_result;
   logic [31:0] final_result;
   wb_bundle_t  wb_bundle;

   // SRAM latency is fixed at one cycle, so the stage is always ready to go.
   assign MEM_allow_in    = ~valid_q | WB_allow_in;
   assign MEM_to_WB_valid = valid_q;
   assign accept          = EX_to_MEM_valid & MEM_allow_in;

   // Slot valid, first-cycle marker and stalled read-data capture; flush beats accept.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
      if (reset | wb_ex) begin
         valid_q      <= 1'b0;
         first_cyc_q  <= 1'b0;
         rdata_hold_q <= 32'h0;
      end else begin
         if (MEM_allow_in)
            valid_q <= EX_to_MEM_valid;
         if (accept) begin
            first_cyc_q <= 1'b1;
         end else if (valid_q & first_cyc_q & ~WB_allow_in) begin
            rdata_hold_q <= data_sram_rdata;
            first_cyc_q  <= 1'b0;
         end else if (MEM_allow_in) begin
            first_cyc_q  <= 1'b0;
         end
      end
   end

   // Bundle register loads on every accept.
   always_ff @(posedge clk) begin
      // NOTE: the bundle is datapath only and is qualified by valid_q, so it carries no reset.
      if (accept)
         bundle_q <= to_MEM_data;
   end

   // The SRAM bus is only meaningful in the first MEM cycle; afterwards use the held copy.
   assign rdata_eff = first_cyc_q ? data_sram_rdata : rdata_hold_q;

   mem_stage_load_align u_load_align (
      .rdata       (rdata_eff),
      .off         (bundle_q.alu_result[1:0]),
      .rd1b        (bundle_q.rd1b),
      .rd2b        (bundle_q.rd2b),
      .rd4b        (bundle_q.rd4b),
      .rd_signed   (bundle_q.rd_signed),
      .load_result (load_result)
   );

   assign any_load     = bundle_q.rd1b | bundle_q.rd2b | bundle_q.rd4b;
   assign final_result = any_load ? load_result : bundle_q.alu_result;

   assign wb_bundle.pc           = bundle_q.pc;
   assign wb_bundle.final_result = final_result;
   assign wb_bundle.dest         = bundle_q.dest;
   assign wb_bundle.gr_we        = bundle_q.gr_we;
   assign wb_bundle.ex_sys       = bundle_q.ex_sys;
   assign to_WB_data             = wb_bundle;

   // Result is final in MEM, so the whole bus is simply gated by slot validity.
   assign MEM_forward = {bundle_q.dest, final_result} & {FWD_W{valid_q}};

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage.
module tb_mem_stage;

   logic        clk;
   logic        reset;
   logic        wb_ex;
   logic        EX_to_MEM_valid;
   logic [74:0] to_MEM_data;
   logic        MEM_allow_in;
   logic [31:0] data_sram_rdata;
   logic        WB_allow_in;
   logic        MEM_to_WB_valid;
   logic [70:0] to_WB_data;
   logic [36:0] MEM_forward;

   int n_pass;
   int n_total;

   mem_stage dut (
      .clk             (clk),
      .reset           (reset),
      .wb_ex           (wb_ex),
      .EX_to_MEM_valid (EX_to_MEM_valid),
      .to_MEM_data     (to_MEM_data),
      .MEM_allow_in    (MEM_allow_in),
      .data_sram_rdata (data_sram_rdata),
      .WB_allow_in     (WB_allow_in),
      .MEM_to_WB_valid (MEM_to_WB_valid),
      .to_WB_data      (to_WB_data),
      .MEM_forward     (MEM_forward)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Bundle builder: {pc, alu, rd1b, rd2b, rd4b, rd_signed, dest, gr_we, ex_SYS}
   function automatic logic [74:0] mk(input logic [31:0] pc, input logic [31:0] alu,
                                      input logic r1, input logic r2, input logic r4,
                                      input logic sg, input logic [4:0] dest);
      return {pc, alu, r1, r2, r4, sg, dest, 1'b1, 1'b0};
   endfunction

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present a bundle for one cycle; returns just after the accepting edge with EX idle.
   task automatic issue(input logic [74:0] b);
      EX_to_MEM_valid = 1'b1;
      to_MEM_data     = b;
      step();
      EX_to_MEM_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      @(negedge clk);
      n_total++;
      if (MEM_to_WB_valid !== 1'b0) $display("FAIL reset_valid got %0b want 0", MEM_to_WB_valid);
      else n_pass++;
      n_total++;
      if (MEM_allow_in !== 1'b1) $display("FAIL reset_allow got %0b want 1", MEM_allow_in);
      else n_pass++;
      n_total++;
      if (MEM_forward !== 37'h0) $display("FAIL reset_fwd got %h want 0", MEM_forward);
      else n_pass++;
      step();
   endtask

   task automatic test_ld_w();
      WB_allow_in = 1'b1;
      issue(mk(32'h1c00_0010, 32'h1000_0004, 1'b0, 1'b0, 1'b1, 1'b0, 5'd5));
      data_sram_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      n_total++;
      if (MEM_to_WB_valid !== 1'b1) $display("FAIL ldw_valid got %0b want 1", MEM_to_WB_valid);
      else n_pass++;
      n_total++;
      if (to_WB_data !== {32'h1c00_0010, 32'hDEAD_BEEF, 5'd5, 1'b1, 1'b0})
         $display("FAIL ldw_wb got %h want %h", to_WB_data,
                  {32'h1c00_0010, 32'hDEAD_BEEF, 5'd5, 1'b1, 1'b0});
      else n_pass++;
      n_total++;
      if (MEM_forward !== {5'd5, 32'hDEAD_BEEF})
         $display("FAIL ldw_fwd got %h want %h", MEM_forward, {5'd5, 32'hDEAD_BEEF});
      else n_pass++;
      step();
      data_sram_rdata = 32'h0;
      @(negedge clk);
      n_total++;
      if (MEM_to_WB_valid !== 1'b0) $display("FAIL ldw_depart got %0b want 0", MEM_to_WB_valid);
      else n_pass++;
      step();
   endtask

   task automatic test_extend();
      // {alu offset, rd1b, rd2b, rd_signed, rdata, expected}
      logic [31:0] alu_t [6] = '{32'h3, 32'h3, 32'h2, 32'h2, 32'h1, 32'h0};
      logic        r1_t  [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      logic        sg_t  [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      logic [31:0] rd_t  [6] = '{32'h8012_3456, 32'h8012_3456, 32'h8001_1234,
                                 32'h8001_1234, 32'h0000_FF00, 32'h1234_ABCD};
      logic [31:0] exp_t [6] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001,
                                 32'h0000_8001, 32'hFFFF_FFFF, 32'h0000_ABCD};
      WB_allow_in = 1'b1;
      for (int i = 0; i < 6; i++) begin
         issue(mk(32'h100 + i, alu_t[i], r1_t[i], ~r1_t[i], 1'b0, sg_t[i], 5'd7));
         data_sram_rdata = rd_t[i];
         @(negedge clk);
         n_total++;
         if (to_WB_data[38:7] !== exp_t[i])
            $display("FAIL extend_%0d got %h want %h", i, to_WB_data[38:7], exp_t[i]);
         else n_pass++;
         step();
      end
   endtask

   task automatic test_stall();
      WB_allow_in = 1'b0;
      issue(mk(32'h200, 32'h1000_0008, 1'b0, 1'b0, 1'b1, 1'b0, 5'd9));
      data_sram_rdata = 32'hDEAD_BEEF;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         n_total++;
         if (to_WB_data[38:7] !== 32'hDEAD_BEEF || MEM_to_WB_valid !== 1'b1)
            $display("FAIL stall_data_%0d got %h/%0b want deadbeef/1", c,
                     to_WB_data[38:7], MEM_to_WB_valid);
         else n_pass++;
         n_total++;
         if (MEM_allow_in !== 1'b0) $display("FAIL stall_allow_%0d got %0b want 0", c, MEM_allow_in);
         else n_pass++;
         step();
         data_sram_rdata = 32'h1234_5678;
      end
      WB_allow_in = 1'b1;
      @(negedge clk);
      n_total++;
      if (to_WB_data[38:7] !== 32'hDEAD_BEEF || MEM_to_WB_valid !== 1'b1 || MEM_allow_in !== 1'b1)
         $display("FAIL stall_release got %h/%0b/%0b want deadbeef/1/1",
                  to_WB_data[38:7], MEM_to_WB_valid, MEM_allow_in);
      else n_pass++;
      step();
      @(negedge clk);
      n_total++;
      if (MEM_to_WB_valid !== 1'b0) $display("FAIL stall_depart got %0b want 0", MEM_to_WB_valid);
      else n_pass++;
      step();
   endtask

   task automatic test_back_to_back();
      WB_allow_in     = 1'b1;
      data_sram_rdata = 32'hCAFE_0000;
      issue(mk(32'h300, 32'h5, 1'b0, 1'b0, 1'b0, 1'b0, 5'd3));
      EX_to_MEM_valid = 1'b1;
      to_MEM_data     = mk(32'h304, 32'h2000_0000, 1'b0, 1'b0, 1'b1, 1'b0, 5'd4);
      @(negedge clk);
      n_total++;
      if (to_WB_data !== {32'h300, 32'h5, 5'd3, 1'b1, 1'b0} || MEM_to_WB_valid !== 1'b1)
         $display("FAIL b2b_add got %h/%0b want %h/1", to_WB_data, MEM_to_WB_valid,
                  {32'h300, 32'h5, 5'd3, 1'b1, 1'b0});
      else n_pass++;
      step();
      EX_to_MEM_valid = 1'b0;
      data_sram_rdata = 32'h77;
      @(negedge clk);
      n_total++;
      if (to_WB_data !== {32'h304, 32'h77, 5'd4, 1'b1, 1'b0} || MEM_to_WB_valid !== 1'b1)
         $display("FAIL b2b_ld got %h/%0b want %h/1", to_WB_data, MEM_to_WB_valid,
                  {32'h304, 32'h77, 5'd4, 1'b1, 1'b0});
      else n_pass++;
      step();
   endtask

   task automatic test_wb_ex();
      WB_allow_in = 1'b0;
      issue(mk(32'h400, 32'h1000_0000, 1'b0, 1'b0, 1'b1, 1'b0, 5'd6));
      data_sram_rdata = 32'h5555_AAAA;
      WB_allow_in     = 1'b1;
      EX_to_MEM_valid = 1'b1;
      to_MEM_data     = mk(32'h404, 32'h9, 1'b0, 1'b0, 1'b0, 1'b0, 5'd8);
      wb_ex           = 1'b1;
      step();
      wb_ex           = 1'b0;
      EX_to_MEM_valid = 1'b0;
      @(negedge clk);
      n_total++;
      if (MEM_to_WB_valid !== 1'b0) $display("FAIL wbex_valid got %0b want 0", MEM_to_WB_valid);
      else n_pass++;
      n_total++;
      if (MEM_forward !== 37'h0) $display("FAIL wbex_fwd got %h want 0", MEM_forward);
      else n_pass++;
      step();
   endtask

   task automatic test_reset_mid_stall();
      WB_allow_in = 1'b0;
      issue(mk(32'h500, 32'h1000_0000, 1'b0, 1'b0, 1'b1, 1'b0, 5'd10));
      data_sram_rdata = 32'hAAAA_5555;
      step();
      data_sram_rdata = 32'h0;
      reset = 1'b1;
      step();
      reset = 1'b0;
      @(negedge clk);
      n_total++;
      if (MEM_to_WB_valid !== 1'b0 || MEM_allow_in !== 1'b1)
         $display("FAIL rst_stall got %0b/%0b want 0/1", MEM_to_WB_valid, MEM_allow_in);
      else n_pass++;
      step();
      issue(mk(32'h600, 32'h1000_0000, 1'b0, 1'b0, 1'b1, 1'b0, 5'd11));
      data_sram_rdata = 32'h0BAD_F00D;
      @(negedge clk);
      n_total++;
      if (to_WB_data[38:7] !== 32'h0BAD_F00D || MEM_to_WB_valid !== 1'b1)
         $display("FAIL rst_live got %h/%0b want 0badf00d/1", to_WB_data[38:7], MEM_to_WB_valid);
      else n_pass++;
      WB_allow_in = 1'b1;
      step();
   endtask

   initial begin
      n_pass          = 0;
      n_total         = 0;
      reset           = 1'b1;
      wb_ex           = 1'b0;
      EX_to_MEM_valid = 1'b0;
      to_MEM_data     = '0;
      data_sram_rdata = 32'h0;
      WB_allow_in     = 1'b1;
      #1;
      test_reset();
      test_ld_w();
      test_extend();
      test_stall();
      test_back_to_back();
      test_wb_ex();
      test_reset_mid_stall();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
